// File: rtl/mc_control.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences fetch, decode,
// execute, memory and writeback over a shared memory port with fixed latency.
module mc_control #(
    parameter int MEM_LAT    = 1,
    parameter bit BLEZALS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lez,
    input  logic        stall,
    output logic [2:0]  state,
    output logic        ir_we,
    output logic        pc_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  ext_op,
    output logic        illegal
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic          last;

    logic [5:0] op, func;
    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
    logic is_beq, is_j, is_jal, is_blez, is_alu, legal;
    logic [2:0] alu_op;
    logic [1:0] alu_ext;
    logic       alu_b;
    logic       unused_instr;

    assign op           = instr[31:26];
    assign func         = instr[5:0];
    assign unused_instr = ^instr[25:6];

    assign is_addu = (op == 6'h00) && (func == 6'h21);
    assign is_subu = (op == 6'h00) && (func == 6'h23);
    assign is_jr   = (op == 6'h00) && (func == 6'h08);
    assign is_ori  = (op == 6'h0d);
    assign is_lui  = (op == 6'h0f);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2b);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);
    assign is_blez = BLEZALS_EN && (op == 6'h3c);
    assign is_alu  = is_addu | is_subu | is_ori | is_lui;
    assign legal   = is_alu | is_jr | is_lw | is_sw | is_beq | is_j | is_jal | is_blez;

    // ALU-op controls are shared by EXEC and WB so the result stays stable while written back
    assign alu_op  = is_subu ? ALU_SUB : (is_ori ? ALU_OR : ALU_ADD);
    assign alu_ext = is_lui ? 2'd2 : 2'd0;
    assign alu_b   = is_ori | is_lui;

    assign last  = (cnt == LAST);
    assign state = cur;

    // Counter restarts on every state change, so it is zero on entry to FETCH and MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= INIT;
            cnt <= '0;
        end else if (!stall) begin
            cur <= nxt;
            cnt <= (nxt != cur) ? '0 : cnt + CW'(1);
        end
    end

    always_comb begin
        nxt        = cur;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        pc_src     = 2'd0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_b  = 1'b0;
        alu_ctrl   = ALU_ADD;
        ext_op     = 2'd0;
        illegal    = 1'b0;
        unique case (cur)
            INIT: nxt = FETCH;
            FETCH: begin
                mem_re = 1'b1;
                if (last) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: begin
                if (!legal) begin
                    illegal = 1'b1;
                    nxt     = FETCH;
                end else begin
                    nxt = EXEC;
                end
            end
            EXEC: begin
                nxt = FETCH;
                if (is_alu) begin
                    alu_ctrl  = alu_op;
                    ext_op    = alu_ext;
                    alu_src_b = alu_b;
                    nxt       = WB;
                end else if (is_lw || is_sw) begin
                    ext_op    = 2'd1;
                    alu_src_b = 1'b1;
                    nxt       = MEM;
                end else if (is_beq) begin
                    alu_ctrl = ALU_SUB;
                    ext_op   = 2'd3;
                    pc_src   = 2'd1;
                    pc_we    = zero;
                end else if (is_j) begin
                    pc_src = 2'd2;
                    pc_we  = 1'b1;
                end else if (is_jr) begin
                    pc_src = 2'd3;
                    pc_we  = 1'b1;
                end else if (is_jal) begin
                    pc_src     = 2'd2;
                    pc_we      = 1'b1;
                    reg_we     = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end else if (is_blez) begin
                    ext_op     = 2'd3;
                    pc_src     = 2'd1;
                    pc_we      = lez;
                    reg_we     = lez;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
            end
            MEM: begin
                ext_op    = 2'd1;
                alu_src_b = 1'b1;
                if (is_lw) begin
                    mem_re = 1'b1;
                    if (last) nxt = WB;
                end else begin
                    mem_we = last & is_sw;
                    if (last) nxt = FETCH;
                end
            end
            WB: begin
                reg_we     = 1'b1;
                reg_dst    = (is_ori || is_lui || is_lw) ? 2'd1 : 2'd0;
                mem_to_reg = is_lw ? 2'd1 : 2'd0;
                if (is_alu) begin
                    alu_ctrl  = alu_op;
                    ext_op    = alu_ext;
                    alu_src_b = alu_b;
                end
                nxt = FETCH;
            end
            default: nxt = INIT;
        endcase
        // Stall freezes sequencing: enables are withheld and re-issued once stall drops
        if (stall) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            mem_we  = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
        end
    end
endmodule
